// File: rtl/risc_seq_if.sv
// Handshake and decode bundle between the instruction sequencer and the RISC datapath/memories.
// The sequencer connects through the master modport, the datapath and memories through slave.
interface risc_seq_if #(
  parameter int AW = 32
);
  logic          imem_req;
  logic          imem_ack;
  logic          ir_load;
  logic          dec_mem_read;
  logic          dec_mem_write;
  logic          dec_reg_write;
  logic          dec_call;
  logic          dec_ret;
  logic          br_taken;
  logic [AW-1:0] br_target;
  logic [AW-1:0] pc;
  logic          pc_load;
  logic [AW-1:0] pc_next;
  logic          dmem_rd_req;
  logic          dmem_wr_req;
  logic          dmem_ack;
  logic          rf_we;

  modport master (
    output imem_req, ir_load, pc_load, pc_next, dmem_rd_req, dmem_wr_req, rf_we,
    input  imem_ack, dec_mem_read, dec_mem_write, dec_reg_write, dec_call, dec_ret,
           br_taken, br_target, pc, dmem_ack
  );

  modport slave (
    input  imem_req, ir_load, pc_load, pc_next, dmem_rd_req, dmem_wr_req, rf_we,
    output imem_ack, dec_mem_read, dec_mem_write, dec_reg_write, dec_call, dec_ret,
           br_taken, br_target, pc, dmem_ack
  );
endinterface

// File: rtl/risc_instr_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer with a hardware return-address stack.
// Define RISC_SEQ_TIMEOUT_EN to add the memory-ack timeout, the ERR state and o_timeout_err.
module risc_instr_sequencer #(
  parameter int AW             = 32,
  parameter int RAS_DEPTH      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_run,
  risc_seq_if.master bus,
  output logic [2:0] o_state,
  output logic       o_ras_err
`ifdef RISC_SEQ_TIMEOUT_EN
  ,
  output logic       o_timeout_err
`endif
);
  // state  | meaning
  // IDLE   | parked, waiting for run
  // FETCH  | imem request outstanding, IR captured on ack
  // DECODE | decode flags settling
  // EXEC   | next PC resolved, RAS push/pop
  // MEM    | dmem read or write outstanding
  // WB     | register-file write, retire
  // ERR    | memory timeout, parked until reset
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam int RW = $clog2(RAS_DEPTH);

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic          w_retire;
  logic [AW-1:0] r_pc_next;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_pc_calc;
  logic          r_mem_rd;
  logic [AW-1:0] r_ras [RAS_DEPTH];
  logic [RW:0]   r_ras_cnt;
  logic [RW-1:0] w_ras_top;
  logic          w_push;
  logic          w_pop;
  logic          w_ras_err_set;
  logic          r_ras_err;
  logic          w_ras_empty;
  logic          w_ras_full;

`ifdef RISC_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] r_wait;
  logic          w_wait_tc;

  assign w_wait_tc = (r_wait == '0);

  // Down-counter reloads on every state change, so each FETCH/MEM entry gets a full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= TW'(TIMEOUT_CYCLES - 1);
    end else if (w_state_nxt != r_state) begin
      r_wait <= TW'(TIMEOUT_CYCLES - 1);
    end else if (!w_wait_tc) begin
      r_wait <= r_wait - TW'(1);
    end
  end

  assign o_timeout_err = (r_state == S_ERR);
`endif

  assign w_ras_empty = (r_ras_cnt == '0);
  assign w_ras_full  = (r_ras_cnt == (RW+1)'(RAS_DEPTH));
  assign w_ras_top   = r_ras_cnt[RW-1:0] - RW'(1);
  assign w_pc_inc    = bus.pc + AW'(1);

  always_comb begin
    w_pc_calc     = w_pc_inc;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_ras_err_set = 1'b0;
    if (bus.dec_ret) begin
      if (w_ras_empty) begin
        w_ras_err_set = 1'b1;
      end else begin
        w_pop     = 1'b1;
        w_pc_calc = r_ras[w_ras_top];
      end
    end else if (bus.dec_call) begin
      w_pc_calc = bus.br_target;
      if (w_ras_full) begin
        w_ras_err_set = 1'b1;
      end else begin
        w_push = 1'b1;
      end
    end else if (bus.br_taken) begin
      w_pc_calc = bus.br_target;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_retire        = 1'b0;
    bus.imem_req    = 1'b0;
    bus.ir_load     = 1'b0;
    bus.dmem_rd_req = 1'b0;
    bus.dmem_wr_req = 1'b0;
    bus.rf_we       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          bus.ir_load = 1'b1;
          w_state_nxt = S_DECODE;
        end
`ifdef RISC_SEQ_TIMEOUT_EN
        else if (w_wait_tc) begin
          w_state_nxt = S_ERR;
        end
`endif
      end
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (bus.dec_mem_read || bus.dec_mem_write) begin
          w_state_nxt = S_MEM;
        end else if (bus.dec_reg_write) begin
          w_state_nxt = S_WB;
        end else begin
          w_retire = 1'b1;
        end
      end
      S_MEM: begin
        bus.dmem_rd_req = r_mem_rd;
        bus.dmem_wr_req = !r_mem_rd;
        if (bus.dmem_ack) begin
          if (r_mem_rd) w_state_nxt = S_WB;
          else          w_retire    = 1'b1;
        end
`ifdef RISC_SEQ_TIMEOUT_EN
        else if (w_wait_tc) begin
          w_state_nxt = S_ERR;
        end
`endif
      end
      S_WB: begin
        bus.rf_we = 1'b1;
        w_retire  = 1'b1;
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_retire) w_state_nxt = i_run ? S_FETCH : S_IDLE;
  end

  // An instruction retiring in EXEC needs its freshly resolved target on the bus that same cycle.
  assign bus.pc_next = (r_state == S_EXEC) ? w_pc_calc : r_pc_next;
  assign bus.pc_load = w_retire;
  assign o_state     = r_state;
  assign o_ras_err   = r_ras_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc_next <= '0;
      r_mem_rd  <= 1'b0;
      r_ras_cnt <= '0;
      r_ras_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_EXEC) begin
        r_pc_next <= w_pc_calc;
        r_mem_rd  <= bus.dec_mem_read;
        if (w_push)        r_ras_cnt <= r_ras_cnt + (RW+1)'(1);
        if (w_pop)         r_ras_cnt <= r_ras_cnt - (RW+1)'(1);
        if (w_ras_err_set) r_ras_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_EXEC && w_push) r_ras[r_ras_cnt[RW-1:0]] <= w_pc_inc;
  end
endmodule
